// File: rtl/hack_cpu_core.sv
// Hack CPU execution core: instruction decode, ALU, and the A/D/PC registers.
// Single-cycle: one instruction retires on each clk edge with inst_valid=1.
// address_m and pc come straight from registers; the jump target and the store
// address always use A as it was before the edge.
module hack_cpu_core #(
    parameter logic [14:0] RESET_PC = 15'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instruction,
    input  logic        inst_valid,
    input  logic [15:0] in_m,
    output logic [15:0] out_m,
    output logic        write_m,
    output logic [14:0] address_m,
    output logic [14:0] pc
);

    // Architectural state
    logic [15:0] a_reg, a_next;
    logic [15:0] d_reg, d_next;
    logic [14:0] pc_reg, pc_next;

    // Instruction fields. Bits [14:13] of a C-instruction carry no meaning.
    logic is_c;
    logic sel_m;
    logic zx, nx, zy, ny, f, no;
    logic dest_a, dest_d, dest_m;
    logic j_lt, j_eq, j_gt;
    logic unused_bits;

    assign is_c        = instruction[15];
    assign sel_m       = instruction[12];
    assign zx          = instruction[11];
    assign nx          = instruction[10];
    assign zy          = instruction[9];
    assign ny          = instruction[8];
    assign f           = instruction[7];
    assign no          = instruction[6];
    assign dest_a      = instruction[5];
    assign dest_d      = instruction[4];
    assign dest_m      = instruction[3];
    assign j_lt        = instruction[2];
    assign j_eq        = instruction[1];
    assign j_gt        = instruction[0];
    assign unused_bits = ^instruction[14:13];

    // ALU datapath: x is always D, y is A or the memory read value
    logic [15:0] alu_x, alu_y;
    logic [15:0] x_pre, y_pre;
    logic [15:0] alu_f;
    logic [15:0] alu_out;
    logic        zr, ng;

    assign alu_x = d_reg;
    assign alu_y = sel_m ? in_m : a_reg;

    // Per-bit operand preconditioning: zero first, then optional invert
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pre
            assign x_pre[gi] = (alu_x[gi] & ~zx) ^ nx;
            assign y_pre[gi] = (alu_y[gi] & ~zy) ^ ny;
        end
    endgenerate

    assign alu_f   = f ? (x_pre + y_pre) : (x_pre & y_pre);
    assign alu_out = no ? ~alu_f : alu_f;
    assign zr      = (alu_out == 16'h0000);
    assign ng      = alu_out[15];

    // Jump decision from the flags of the result computed this cycle
    logic        take_jump;
    logic [14:0] pc_inc;

    assign take_jump = (j_lt & ng) | (j_eq & zr) | (j_gt & ~zr & ~ng);
    assign pc_inc    = pc_reg + 15'd1;

    // Next-state selection; a stalled cycle holds every register
    always_comb begin
        a_next  = a_reg;
        d_next  = d_reg;
        pc_next = pc_reg;
        if (inst_valid) begin
            if (!is_c) begin
                a_next  = instruction;
                pc_next = pc_inc;
            end else begin
                if (dest_a) a_next = alu_out;
                if (dest_d) d_next = alu_out;
                pc_next = take_jump ? a_reg[14:0] : pc_inc;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg  <= 16'h0000;
            d_reg  <= 16'h0000;
            pc_reg <= RESET_PC;
        end else begin
            a_reg  <= a_next;
            d_reg  <= d_next;
            pc_reg <= pc_next;
        end
    end

    assign out_m     = alu_out;
    assign write_m   = rst_n & inst_valid & is_c & dest_m;
    assign address_m = a_reg[14:0];
    assign pc        = pc_reg;

endmodule

// File: tb/tb_hack_cpu_core.sv
// Self-checking bench for hack_cpu_core: directed scenarios followed by
// random instruction streams checked against an instruction-level model.
module tb_hack_cpu_core;

    localparam logic [14:0] RESET_PC = 15'h0000;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruction;
    logic        inst_valid;
    logic [15:0] in_m;
    logic [15:0] out_m;
    logic        write_m;
    logic [14:0] address_m;
    logic [14:0] pc;

    hack_cpu_core #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instruction(instruction),
        .inst_valid (inst_valid),
        .in_m       (in_m),
        .out_m      (out_m),
        .write_m    (write_m),
        .address_m  (address_m),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [15:0] m_a, m_d;
    logic [14:0] m_pc;

    // Outputs observed before the edge of the most recent cycle
    logic [15:0] obs_out;
    logic        obs_wr;
    logic [14:0] obs_addr;
    logic [14:0] obs_pc;

    // The 18 defined Hack comp encodings
    localparam logic [5:0] COMP_TAB [0:17] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };

    // Hack comp mnemonics expressed as plain arithmetic
    function automatic logic [15:0] ref_alu(input logic [5:0] comp, input logic [15:0] x,
                                            input logic [15:0] y);
        logic [15:0] r;
        case (comp)
            6'b101010: r = 16'h0000;
            6'b111111: r = 16'h0001;
            6'b111010: r = 16'hFFFF;
            6'b001100: r = x;
            6'b110000: r = y;
            6'b001101: r = ~x;
            6'b110001: r = ~y;
            6'b001111: r = 16'h0000 - x;
            6'b110011: r = 16'h0000 - y;
            6'b011111: r = x + 16'h0001;
            6'b110111: r = y + 16'h0001;
            6'b001110: r = x - 16'h0001;
            6'b110010: r = y - 16'h0001;
            6'b000010: r = x + y;
            6'b010011: r = x - y;
            6'b000111: r = y - x;
            6'b000000: r = x & y;
            6'b010101: r = x | y;
            default:   r = 16'hxxxx;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle, check pre-edge outputs against the model, then advance the model
    task automatic do_cycle(input logic [15:0] instr, input logic v, input logic [15:0] inm,
                            input logic rn);
        logic [15:0] y, r, old_a;
        logic        exp_wr, jmp;
        instruction = instr;
        inst_valid  = v;
        in_m        = inm;
        rst_n       = rn;
        #1;
        y      = instr[12] ? inm : m_a;
        r      = ref_alu(instr[11:6], m_d, y);
        exp_wr = rn & v & instr[15] & instr[3];
        jmp    = instr[15] && ((instr[2] && $signed(r) < 0) || (instr[1] && r == 16'h0000) ||
                               (instr[0] && $signed(r) > 0));
        obs_out  = out_m;
        obs_wr   = write_m;
        obs_addr = address_m;
        obs_pc   = pc;
        check("pc", {1'b0, pc}, {1'b0, m_pc});
        check("address_m", {1'b0, address_m}, {1'b0, m_a[14:0]});
        check("write_m", {15'd0, write_m}, {15'd0, exp_wr});
        if (instr[15]) check("out_m", out_m, r);
        @(posedge clk);
        #1;
        old_a = m_a;
        if (!rn) begin
            m_a  = 16'h0000;
            m_d  = 16'h0000;
            m_pc = RESET_PC;
        end else if (v) begin
            if (!instr[15]) begin
                m_a  = instr;
                m_pc = m_pc + 15'd1;
            end else begin
                if (instr[5]) m_a = r;
                if (instr[4]) m_d = r;
                m_pc = jmp ? old_a[14:0] : m_pc + 15'd1;
            end
        end
    endtask

    // Read A and D through the ALU while stalled (no state change)
    task automatic peek(output logic [15:0] a_obs, output logic [15:0] d_obs);
        inst_valid  = 1'b0;
        instruction = 16'hE300;   // comp D
        #1;
        d_obs = out_m;
        instruction = 16'hEC00;   // comp A
        #1;
        a_obs = out_m;
    endtask

    // Safety net against a hung run
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] pa, pd, instr;
        logic [14:0] saved_pc;
        logic        v, rn;

        // Reset held for two cycles with a store instruction presented
        rst_n       = 1'b0;
        instruction = 16'hE308;
        inst_valid  = 1'b1;
        in_m        = 16'h1234;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("reset_write_m", {15'd0, write_m}, 16'h0000);
            @(posedge clk);
            #1;
        end
        m_a = 16'h0000; m_d = 16'h0000; m_pc = RESET_PC;
        peek(pa, pd);
        check("reset_a", pa, 16'h0000);
        check("reset_d", pd, 16'h0000);
        check("reset_pc", {1'b0, pc}, {1'b0, RESET_PC});

        // Store sequence: RAM[100] = 5
        do_cycle(16'h0005, 1'b1, 16'h0000, 1'b1);
        check("seq_pc0", {1'b0, obs_pc}, 16'h0000);
        do_cycle(16'hEC10, 1'b1, 16'h0000, 1'b1);
        check("seq_pc1", {1'b0, obs_pc}, 16'h0001);
        do_cycle(16'h0064, 1'b1, 16'h0000, 1'b1);
        check("seq_pc2", {1'b0, obs_pc}, 16'h0002);
        do_cycle(16'hE308, 1'b1, 16'h0000, 1'b1);
        check("seq_pc3", {1'b0, obs_pc}, 16'h0003);
        check("seq_out", obs_out, 16'h0005);
        check("seq_addr", {1'b0, obs_addr}, 16'h0064);
        check("seq_wr", {15'd0, obs_wr}, 16'h0001);
        check("seq_pc4", {1'b0, pc}, 16'h0004);

        // Jumps
        do_cycle(16'hEA90, 1'b1, 16'h0000, 1'b1);
        do_cycle(16'h000A, 1'b1, 16'h0000, 1'b1);
        do_cycle(16'hE302, 1'b1, 16'h0000, 1'b1);
        check("jeq_taken", {1'b0, pc}, 16'h000A);
        do_cycle(16'hE301, 1'b1, 16'h0000, 1'b1);
        check("jgt_not_taken", {1'b0, pc}, 16'h000B);
        do_cycle(16'h0020, 1'b1, 16'h0000, 1'b1);
        do_cycle(16'hEA87, 1'b1, 16'h0000, 1'b1);
        check("jmp_taken", {1'b0, pc}, 16'h0020);

        // Stall
        do_cycle(16'h0011, 1'b1, 16'h0000, 1'b1);
        do_cycle(16'hEC10, 1'b1, 16'h0000, 1'b1);
        do_cycle(16'h0003, 1'b1, 16'h0000, 1'b1);
        saved_pc = pc;
        for (int i = 0; i < 3; i++) begin
            do_cycle(16'hE318, 1'b0, 16'h0000, 1'b1);
            check("stall_wr", {15'd0, obs_wr}, 16'h0000);
            check("stall_pc", {1'b0, pc}, {1'b0, saved_pc});
        end
        peek(pa, pd);
        check("stall_a", pa, 16'h0003);
        check("stall_d", pd, 16'h0011);
        do_cycle(16'hE318, 1'b1, 16'h0000, 1'b1);
        check("unstall_wr", {15'd0, obs_wr}, 16'h0001);
        check("unstall_out", obs_out, 16'h0011);
        check("unstall_addr", {1'b0, obs_addr}, 16'h0003);
        check("unstall_pc", {1'b0, pc}, {1'b0, saved_pc + 15'd1});

        // Read-modify-write with overflow into bit 15 of A
        do_cycle(16'h0007, 1'b1, 16'h0000, 1'b1);
        do_cycle(16'hFDE8, 1'b1, 16'h7FFF, 1'b1);
        check("rmw_out", obs_out, 16'h8000);
        check("rmw_wr", {15'd0, obs_wr}, 16'h0001);
        check("rmw_addr", {1'b0, obs_addr}, 16'h0007);
        peek(pa, pd);
        check("rmw_a", pa, 16'h8000);
        check("rmw_addr_after", {1'b0, address_m}, 16'h0000);

        // PC wrap, then reset mid-program
        do_cycle(16'h7FFF, 1'b1, 16'h0000, 1'b1);
        do_cycle(16'hEA87, 1'b1, 16'h0000, 1'b1);
        check("wrap_pc_top", {1'b0, pc}, 16'h7FFF);
        do_cycle(16'h0000, 1'b1, 16'h0000, 1'b1);
        check("wrap_pc_zero", {1'b0, pc}, 16'h0000);
        do_cycle(16'h0009, 1'b1, 16'h0000, 1'b1);
        do_cycle(16'hEC10, 1'b1, 16'h0000, 1'b0);
        peek(pa, pd);
        check("midreset_d", pd, 16'h0000);
        check("midreset_a", pa, 16'h0000);
        check("midreset_pc", {1'b0, pc}, {1'b0, RESET_PC});

        // Random instruction stream against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(1, 0) == 0) begin
                instr = {1'b0, 15'($urandom)};
            end else begin
                instr = {1'b1, 2'($urandom), 1'($urandom), COMP_TAB[$urandom_range(17, 0)],
                         3'($urandom), 3'($urandom)};
            end
            v  = ($urandom_range(3, 0) != 0);
            rn = ($urandom_range(39, 0) != 0);
            do_cycle(instr, v, 16'($urandom), rn);
        end
        peek(pa, pd);
        check("final_a", pa, m_a);
        check("final_d", pd, m_d);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hack_cpu_core.md
Name: hack_cpu_core

Overview:
Hack CPU execution core that sits directly upstream of the 16-bit ALU and feeds it.
- Decodes each Hack instruction into the six ALU control bits and selects the ALU x/y operands.
- Owns the architectural A, D and PC registers, evaluates jump conditions from the ALU zr/ng flags, and drives the data-memory write port.
- An instruction-valid qualifier lets the fetch side stall the core.

Parameters:
RESET_PC, 15'h0000, PC value loaded on reset.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  reset; synchronous, active-low
instruction  input  16  current instruction from ROM at address pc
inst_valid  input  1  1 = instruction is valid this cycle; 0 = stall
in_m  input  16  data memory read value at address_m (combinational from RAM)
out_m  output  16  ALU result (data to write to memory)
write_m  output  1  1 = write out_m to RAM[address_m] at this clock edge
address_m  output  15  data memory address = A[14:0]
pc  output  15  address of next/current instruction fetch

Behaviour:
- Reset: synchronous, active-low. On a clk edge with rst_n=0: A<=0, D<=0, PC<=RESET_PC. Reset overrides inst_valid.
  - While rst_n=0, write_m is forced 0.
  - Reset asserted mid-program discards the in-flight instruction (no register or memory write).
- Instruction decode:
  - A-instruction: instruction[15]=0. A<=instruction (bit 15 is 0); D unchanged; write_m=0; PC<=PC+1.
  - C-instruction: instruction[15]=1; bits [14:13] are ignored.
    - a=[12]; comp=[11:6] maps in order to zx,nx,zy,ny,f,no.
    - dest: [5]=A, [4]=D, [3]=M.
    - jump: [2]=lt, [1]=eq, [0]=gt.
- ALU operands: x=D; y = a ? in_m : A. out_m = ALU out (combinational, same cycle). For A-instructions out_m is don't-care.
- Stores: write_m = rst_n & inst_valid & instruction[15] & instruction[3] (combinational).
- Register updates, C-instruction, at the edge when inst_valid=1:
  - dest A => A<=out_m.
  - dest D => D<=out_m.
- Jump condition: jmp = (lt&ng) | (eq&zr) | (gt&~zr&~ng), using the ALU flags of the current out_m.
  - jmp=1 => PC<=A[14:0], using the pre-update A.
  - Otherwise PC<=PC+1.
- Same-instruction ordering: address_m and the jump target always use A as it was before this edge. Example: "AM=M+1;JMP" writes to and jumps to the old A.
- PC arithmetic: 15-bit, wraps 15'h7FFF -> 15'h0000 silently.
- Stall: inst_valid=0 => A, D, PC hold; write_m=0; outputs otherwise follow current state.
- Latency: single-cycle; one instruction retires per clk with inst_valid=1.
- pc and address_m are direct register outputs (no combinational path from instruction to pc).

Test Plan:
1. Reset: rst_n=0 for 2 clks with instruction=0xE308, inst_valid=1 -> write_m=0 throughout; after release pc=0, A=0, D=0.
2. Store sequence 0x0005, 0xEC10, 0x0064, 0xE308, each with inst_valid=1 -> pc steps 0,1,2,3,4; on the 4th cycle out_m=0x0005, address_m=0x0064, write_m=1.
3. Jumps: 0xEA90 (D=0), 0x000A, 0xE302 (D;JEQ) -> next pc=0x000A. Repeat with 0xE301 (D;JGT) -> pc=prev+1. 0xEA87 (0;JMP) with A=0x0020 -> pc=0x0020.
4. Stall: after A=0x0003, D=0x0011, hold inst_valid=0 for 3 clks with instruction=0xE318 -> pc, A, D unchanged; write_m=0 every cycle. Raise inst_valid -> executes once.
5. Read-modify-write and overflow: A=0x0007, in_m=0x7FFF, instruction 0xFDE8 (AM=M+1) -> out_m=0x8000, write_m=1, address_m=0x0007. Next cycle A=0x8000, address_m=0x0000.
6. PC wrap and mid-run reset: 0x7FFF then 0xEA87 -> pc=0x7FFF; next 0x0000 -> pc=0x0000. Assert rst_n=0 while instruction=0xEC10 -> D stays 0, pc=RESET_PC.
